inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, instruction memory address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 64, instruction word width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_tdata  input  DATA_WIDTH  program word, AXI-Stream slave.
REQ-006 s_tvalid  input  1  program word valid.
REQ-007 s_tready  output  1  loader accepts word.
REQ-008 s_tlast  input  1  last word of program.
REQ-009 load_req  input  1  single-cycle pulse requesting a program reload while in RUN.
REQ-010 cpu_halt  output  1  holds CPU stalled; high whenever state is not RUN.
REQ-011 cpu_rd_en, cpu_rd_addr  input  1, ADDR_WIDTH  CPU fetch request.
REQ-012 mem_wr_en, mem_wr_addr, mem_wr_data  output  1, ADDR_WIDTH, DATA_WIDTH  memory write port.
REQ-013 mem_rd_en, mem_rd_addr  output  1, ADDR_WIDTH  memory read port.
REQ-014 prog_len  output  ADDR_WIDTH+1  number of words in last completed program.
REQ-015 err  output  1  sticky overflow flag (see Configuration).

Function
REQ-016 States: IDLE, LOAD, COMMIT, RUN; after reset the state SHALL be IDLE.
REQ-017 s_tready SHALL be 1 in IDLE and LOAD, 0 in COMMIT and RUN.
REQ-018 Accept = s_tvalid & s_tready; IDLE->LOAD on the first accepted word without s_tlast; IDLE->COMMIT on an accepted word with s_tlast.
REQ-019 Write pointer wr_ptr SHALL be 0 on entering IDLE and increment by 1 per accepted word.
REQ-020 Each accepted word SHALL produce mem_wr_en=1 exactly one cycle later, with mem_wr_addr=wr_ptr at accept time and mem_wr_data=s_tdata at accept time; mem_wr_* outputs are registered.
REQ-021 LOAD->COMMIT on an accepted word with s_tlast; prog_len SHALL update to wr_ptr+1 in the same edge.
REQ-022 COMMIT lasts exactly one cycle (the final write issues in it) then ->RUN; cpu_halt falls on the cycle after the final mem_wr_en.
REQ-023 mem_rd_en SHALL equal cpu_rd_en in RUN and 0 otherwise; mem_rd_addr SHALL equal cpu_rd_addr at all times (combinational).
REQ-024 RUN->IDLE on load_req=1; load_req outside RUN SHALL be ignored; s_tvalid in RUN SHALL be left unaccepted (backpressured).
REQ-025 Simultaneous cpu_rd_en and write never co-occur at the memory, since writes occur only outside RUN and reads only in RUN.
REQ-026 s_tvalid may deassert mid-program; LOAD holds with no write issued.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, wr_ptr 0, mem_wr_en 0, mem_wr_addr 0, mem_wr_data 0, prog_len 0, err 0, cpu_halt 1, s_tready 1 after release.
REQ-028 Reset during LOAD SHALL abandon the partial program; memory contents are not cleared and prog_len reads 0.

Configuration
REQ-029 Macro INST_MEM_LOADER_OVF_CHECK_EN selects overflow handling.
REQ-030 With it defined: a word accepted when wr_ptr==DEPTH (program longer than DEPTH) SHALL set err, produce no write, and further words SHALL be accepted and discarded until s_tlast; then ->IDLE (not RUN), prog_len unchanged; err clears on next accepted word in IDLE.
REQ-031 Without it: wr_ptr is ADDR_WIDTH bits, wraps DEPTH-1->0, later words overwrite from address 0, err tied 0, prog_len = accepted count modulo 2**(ADDR_WIDTH+1).

Verification
REQ-032 Reset, then 4 words A,B,C,D (tlast on D) -> writes addr 0..3 with A..D one cycle after each accept, prog_len=4, cpu_halt low 1 cycle after last write.
REQ-033 Single word with tlast from IDLE -> one write at addr 0, IDLE->COMMIT->RUN, prog_len=1.
REQ-034 In RUN, cpu_rd_en=1 addr 5 -> mem_rd_en=1 addr 5 same cycle; s_tvalid=1 held -> s_tready stays 0.
REQ-035 load_req in RUN then 2 words -> cpu_halt high next cycle, writes at addr 0,1, prog_len=2.
REQ-036 ADDR_WIDTH=2, 6 words: with macro -> err=1, writes only addr 0..3, ends in IDLE; without -> addr sequence 0,1,2,3,0,1, prog_len=6.
REQ-037 rst_n low after 3 of 5 words -> mem_wr_en 0 immediately, cpu_halt 1, next word written at addr 0.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Streams a program from an AXI-Stream slave into instruction memory, holding the CPU in halt until
// the program is committed. Define INST_MEM_LOADER_OVF_CHECK_EN to flag and discard over-length programs.
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic                  load_req,
  output logic                  cpu_halt,
  input  logic                  cpu_rd_en,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_RUN} state_e;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     wr_cnt_q, wr_cnt_d;     // words accepted in the current program
  logic [ADDR_WIDTH:0]     prog_len_q, prog_len_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                    accept;
  logic                    ovf_hit;

`ifdef INST_MEM_LOADER_OVF_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  logic err_q, err_d;

  // The counter parks at DEPTH once full, so every later word of the same program also hits this.
  assign ovf_hit = (wr_cnt_q == DEPTH_CNT);
  assign err     = err_q;
`else
  // Without checking, the low address bits wrap and later words overwrite from address 0.
  assign ovf_hit = 1'b0;
  assign err     = 1'b0;
`endif

  assign s_tready    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept      = s_tvalid && s_tready;
  assign cpu_halt    = (state_q != S_RUN);
  assign mem_rd_en   = (state_q == S_RUN) && cpu_rd_en;
  assign mem_rd_addr = cpu_rd_addr;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign prog_len    = prog_len_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned
    // and infer a latch.
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    prog_len_d    = prog_len_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
`ifdef INST_MEM_LOADER_OVF_CHECK_EN
    err_d         = err_q;
`endif

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
`ifdef INST_MEM_LOADER_OVF_CHECK_EN
          if (state_q == S_IDLE) err_d = 1'b0;
          if (ovf_hit)           err_d = 1'b1;
`endif
          if (!ovf_hit) begin
            mem_wr_en_d   = 1'b1;
            mem_wr_addr_d = wr_cnt_q[ADDR_WIDTH-1:0];
            mem_wr_data_d = s_tdata;
            wr_cnt_d      = wr_cnt_q + CNT_ONE;
          end
          if (s_tlast) begin
            wr_cnt_d = '0;
            if (ovf_hit) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_COMMIT;
              prog_len_d = wr_cnt_q + CNT_ONE;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_COMMIT: state_d = S_RUN;
      S_RUN: begin
        if (load_req) begin
          state_d  = S_IDLE;
          wr_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_cnt_q      <= '0;
      prog_len_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
`ifdef INST_MEM_LOADER_OVF_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      prog_len_q    <= prog_len_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
`ifdef INST_MEM_LOADER_OVF_CHECK_EN
      err_q         <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed-random bench for inst_mem_loader: programs of random words, checked against an
// arithmetic model of write addresses, program length and overflow behaviour.
module tb_inst_mem_loader;

  localparam int AW    = 3;
  localparam int DW    = 64;
  localparam int DEPTH = 2**AW;
`ifdef INST_MEM_LOADER_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic          load_req;
  logic          cpu_halt;
  logic          cpu_rd_en;
  logic [AW-1:0] cpu_rd_addr;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [AW:0]   prog_len;
  logic          err;

  int checks = 0;
  int errors = 0;
  int model_plen = 0;

  inst_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .load_req(load_req), .cpu_halt(cpu_halt),
    .cpu_rd_en(cpu_rd_en), .cpu_rd_addr(cpu_rd_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .prog_len(prog_len), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n words with random gaps; with finish set the last one carries tlast.
  task automatic send_words(input int n, input bit finish);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        s_tvalid = 1'b0;
        s_tdata  = {$urandom, $urandom};
        step();
        check("gap_no_wr", 64'(mem_wr_en), 64'd0);
      end
      d        = {$urandom, $urandom};
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = finish && (i == n - 1);
      check("tready_load", 64'(s_tready), 64'd1);
      step();
      if (OVF_EN && i >= DEPTH) begin
        check("ovf_no_wr", 64'(mem_wr_en), 64'd0);
        check("ovf_err", 64'(err), 64'd1);
      end else begin
        check("wr_en", 64'(mem_wr_en), 64'd1);
        check("wr_addr", 64'(mem_wr_addr), 64'(i % DEPTH));
        check("wr_data", mem_wr_data, d);
        check("err_low", 64'(err), 64'd0);
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (finish) begin
      if (OVF_EN && n > DEPTH) begin
        check("ovf_halt", 64'(cpu_halt), 64'd1);
        check("ovf_prog_len", 64'(prog_len), 64'(model_plen));
        step();
        check("ovf_idle_tready", 64'(s_tready), 64'd1);
        check("ovf_idle_halt", 64'(cpu_halt), 64'd1);
      end else begin
        model_plen = n % (2 * DEPTH);
        check("prog_len", 64'(prog_len), 64'(model_plen));
        check("commit_halt", 64'(cpu_halt), 64'd1);
        check("commit_tready", 64'(s_tready), 64'd0);
        step();
        check("run_halt", 64'(cpu_halt), 64'd0);
        check("run_no_wr", 64'(mem_wr_en), 64'd0);
      end
    end
  endtask

  task automatic run_reads();
    logic [AW-1:0] a;
    for (int k = 0; k < 6; k++) begin
      a           = (k == 0) ? AW'(5) : AW'($urandom_range(0, DEPTH - 1));
      cpu_rd_en   = (k != 3);
      cpu_rd_addr = a;
      s_tvalid    = 1'b1;
      s_tdata     = {$urandom, $urandom};
      #1;
      check("rd_en", 64'(mem_rd_en), 64'(k != 3));
      check("rd_addr", 64'(mem_rd_addr), 64'(a));
      check("run_backpressure", 64'(s_tready), 64'd0);
      step();
      check("run_no_wr_tvalid", 64'(mem_wr_en), 64'd0);
      check("run_halt_low", 64'(cpu_halt), 64'd0);
    end
    s_tvalid  = 1'b0;
    cpu_rd_en = 1'b0;
  endtask

  task automatic reload();
    cpu_rd_en = 1'b1;
    load_req  = 1'b1;
    step();
    load_req  = 1'b0;
    check("reload_halt", 64'(cpu_halt), 64'd1);
    check("reload_tready", 64'(s_tready), 64'd1);
    check("reload_no_rd", 64'(mem_rd_en), 64'd0);
    cpu_rd_en = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
    check("rst_wr_data", mem_wr_data, 64'd0);
    check("rst_prog_len", 64'(prog_len), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_halt", 64'(cpu_halt), 64'd1);
    check("rst_tready", 64'(s_tready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n       = 1'b0;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    load_req    = 1'b0;
    cpu_rd_en   = 1'b0;
    cpu_rd_addr = '0;
    #1;
    check_reset_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send_words(4, 1'b1);
    run_reads();
    reload();
    send_words(2, 1'b1);
    reload();
    send_words(1, 1'b1);
    run_reads();
    reload();
    send_words(DEPTH + 2, 1'b1);
    reload();
    send_words(2 * DEPTH + 2, 1'b1);
    reload();
    send_words(3, 1'b1);
    reload();

    // Abandon a partial program with an asynchronous reset while a write is in flight.
    send_words(3, 1'b0);
    check("abort_pre_wr", 64'(mem_wr_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    model_plen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send_words(5, 1'b1);
    run_reads();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
